// File: rtl/fp16_round_pack.sv
// fp16_round_pack: normalize, round-to-nearest-even and pack a raw binary16 product, two-stage valid/ready pipeline.
// Optional macro SUBNORMAL_EN: tiny results become rounded subnormals instead of flushing to zero.
module fp16_round_pack #(
    parameter int EW = 7,
    parameter int MW = 22
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          IN_SIGN,
    input  logic [EW-1:0] IN_EXP,
    input  logic [MW-1:0] IN_MANT,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [15:0]   Q,
    output logic [4:0]    FLAGS
);

`ifdef SUBNORMAL_EN
    // The hidden bit is only needed when denormalizing.
    localparam int SIG_W = 11;
`else
    localparam int SIG_W = 10;
`endif

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic [EW:0]      s1_exp_reg;
    logic [SIG_W-1:0] s1_sig_reg;
    logic             s1_g_reg;
    logic             s1_s_reg;
    logic             s1_zero_reg;

    logic             out_valid_reg;
    logic [15:0]      q_reg;
    logic [4:0]       flags_reg;

    logic             s1_adv;
    logic             s2_adv;

    logic             inc;
    logic [10:0]      frac_sum;
    logic [EW:0]      exp_r;
    logic             tiny;
    logic [15:0]      q_next;
    logic [4:0]       flags_next;

    assign s2_adv    = !out_valid_reg || OUT_READY;
    assign s1_adv    = !s1_valid_reg || s2_adv;
    assign IN_READY  = s1_adv;
    assign OUT_VALID = out_valid_reg;
    assign Q         = q_reg;
    assign FLAGS     = flags_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_sig_reg   <= '0;
            s1_g_reg     <= 1'b0;
            s1_s_reg     <= 1'b0;
            s1_zero_reg  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= IN_VALID;
            if (IN_VALID) begin
                s1_sign_reg <= IN_SIGN;
                s1_zero_reg <= (IN_MANT == '0);
                // A product in [2,4) gains one exponent step.
                s1_exp_reg  <= {IN_EXP[EW-1], IN_EXP} + {{EW{1'b0}}, IN_MANT[MW-1]};
                if (IN_MANT[MW-1]) begin
                    s1_sig_reg <= IN_MANT[MW-11 +: SIG_W];
                    s1_g_reg   <= IN_MANT[MW-12];
                    s1_s_reg   <= |IN_MANT[MW-13:0];
                end else begin
                    s1_sig_reg <= IN_MANT[MW-12 +: SIG_W];
                    s1_g_reg   <= IN_MANT[MW-13];
                    s1_s_reg   <= |IN_MANT[MW-14:0];
                end
            end
        end
    end

`ifdef SUBNORMAL_EN
    logic [EW:0]  amt_full;
    logic [3:0]   amt;
    logic [23:0]  sh_vec;
    logic         sub_g;
    logic         sub_s;
    logic         sub_inexact;
    logic [10:0]  sub_sum;

    // Denormalize: bits shifted past the guard position fold into sticky; carry into bit 10 yields the smallest normal.
    always_comb begin
        amt_full    = (EW+1)'(1) - s1_exp_reg;
        amt         = (amt_full > (EW+1)'(12)) ? 4'd12 : amt_full[3:0];
        sh_vec      = {s1_sig_reg, s1_g_reg, 12'd0} >> amt;
        sub_g       = sh_vec[12];
        sub_s       = (|sh_vec[11:0]) | s1_s_reg;
        sub_sum     = sh_vec[23:13] + {10'd0, sub_g & (sub_s | sh_vec[13])};
        sub_inexact = sub_g | sub_s;
    end
`endif

    always_comb begin
        inc        = s1_g_reg & (s1_s_reg | s1_sig_reg[0]);
        frac_sum   = {1'b0, s1_sig_reg[9:0]} + {10'd0, inc};
        exp_r      = s1_exp_reg + {{EW{1'b0}}, frac_sum[10]};
        tiny       = s1_exp_reg[EW] || (s1_exp_reg == '0);
        q_next     = {s1_sign_reg, 15'd0};
        flags_next = 5'b00000;
        if (s1_zero_reg) begin
            q_next     = {s1_sign_reg, 15'd0};
            flags_next = 5'b00000;
        end else if (tiny) begin
`ifdef SUBNORMAL_EN
            q_next     = {s1_sign_reg, 4'd0, sub_sum};
            flags_next = {2'b00, sub_inexact, 1'b0, sub_inexact};
`else
            q_next     = {s1_sign_reg, 15'd0};
            flags_next = 5'b00101;
`endif
        end else if (exp_r >= (EW+1)'(31)) begin
            q_next     = {s1_sign_reg, 5'h1F, 10'd0};
            flags_next = 5'b00011;
        end else begin
            q_next     = {s1_sign_reg, exp_r[4:0], frac_sum[9:0]};
            flags_next = {4'b0000, s1_g_reg | s1_s_reg};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_reg <= 1'b0;
            q_reg         <= 16'h0000;
            flags_reg     <= 5'b00000;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                q_reg     <= q_next;
                flags_reg <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_fp16_round_pack.sv
// Scoreboard bench for fp16_round_pack: directed vectors, backpressure, async reset, then random traffic vs an arithmetic model.
// Build with +define+SUBNORMAL_EN to exercise gradual underflow.
module tb_fp16_round_pack;

    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_SIGN;
    logic [6:0]  IN_EXP;
    logic [21:0] IN_MANT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] Q;
    logic [4:0]  FLAGS;

    fp16_round_pack dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_SIGN   (IN_SIGN),
        .IN_EXP    (IN_EXP),
        .IN_MANT   (IN_MANT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Q         (Q),
        .FLAGS     (FLAGS)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_out = 0;
    logic [20:0] sb[$];
    bit          rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Exact round-to-nearest-even of the whole product by integer division; returns {Q, FLAGS}.
    function automatic logic [20:0] model(input logic s, input int e, input int m);
        int     p;
        int     ex;
        int     k;
        longint qv;
        longint rem;
        longint half;
        bit     inexact;
        logic [4:0] fl;
        if (m == 0) return {s, 15'd0, 5'd0};
        p  = (m >= (1 << 21)) ? 21 : 20;
        ex = e + p - 20;
`ifndef SUBNORMAL_EN
        if (ex <= 0) return {s, 15'd0, 5'b00101};
`endif
        k = p - 10 + ((ex < 1) ? (1 - ex) : 0);
        if (k > 40) k = 40;
        qv      = longint'(m) >> k;
        rem     = longint'(m) - (qv << k);
        half    = longint'(1) << (k - 1);
        inexact = (rem != 0);
        if (rem > half || (rem == half && qv[0])) qv++;
        if (ex >= 1) begin
            if (qv == 2048) begin
                qv = 1024;
                ex++;
            end
            if (ex >= 31) return {s, 5'h1F, 10'd0, 5'b00011};
            return {s, 5'(ex), 10'(qv - 1024), 4'b0000, inexact};
        end
        fl = inexact ? 5'b00101 : 5'b00000;
        if (qv == 1024) return {s, 5'd1, 10'd0, fl};
        return {s, 5'd0, 10'(qv), fl};
    endfunction

    // Called aligned 1 time unit after a rising edge; returns at the same alignment after acceptance.
    task automatic send(input logic s, input logic [6:0] e, input logic [21:0] m, input logic [20:0] expv);
        int guard;
        guard    = 0;
        IN_VALID = 1'b1;
        IN_SIGN  = s;
        IN_EXP   = e;
        IN_MANT  = m;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            guard++;
            if (guard > 1000) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: IN_READY stuck at %b, required 1", IN_READY);
                break;
            end
        end
        @(posedge CLK);
        #1;
        sb.push_back(expv);
        IN_VALID = 1'b0;
    endtask

    // Monitor: IN_READY occupancy rule, output hold while stalled, in-order results.
    initial begin : monitor
        bit          hold_valid;
        logic [20:0] hold_q;
        logic [20:0] expv;
        hold_valid = 0;
        hold_q     = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                hold_valid = 0;
            end else begin
                check("in_ready", {31'd0, IN_READY}, {31'd0, (OUT_READY || (sb.size() < 2))});
                if (hold_valid) check("q_stable", {11'd0, Q, FLAGS}, {11'd0, hold_q});
                if (OUT_VALID) begin
                    if (OUT_READY) begin
                        hold_valid = 0;
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL unexpected_output: got q=%h flags=%b, required no output", Q, FLAGS);
                        end else begin
                            expv = sb.pop_front();
                            n_out++;
                            $display("txn %0d: q=%h flags=%b (expected q=%h flags=%b)", n_out, Q, FLAGS, expv[20:5], expv[4:0]);
                            check("result", {11'd0, Q, FLAGS}, {11'd0, expv});
                        end
                    end else begin
                        hold_valid = 1;
                        hold_q     = {Q, FLAGS};
                    end
                end else begin
                    hold_valid = 0;
                end
            end
        end
    end

    logic        r_s;
    int          r_e;
    int          r_m;

    initial begin
        CLK       = 1'b0;
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_SIGN   = 1'b0;
        IN_EXP    = '0;
        IN_MANT   = '0;
        OUT_READY = 1'b1;
        rand_done = 0;

        #12;
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_q", {16'd0, Q}, 32'd0);
        check("rst_flags", {27'd0, FLAGS}, 32'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("ready_after_rst", {31'd0, IN_READY}, 32'd1);

        // Latency: idle pipe, result visible on the second sampling point after acceptance.
        send(1'b0, 7'd15, 22'h100000, {16'h3C00, 5'b00000});
        @(negedge CLK);
        check("latency_early", {31'd0, OUT_VALID}, 32'd0);
        @(negedge CLK);
        check("latency_due", {31'd0, OUT_VALID}, 32'd1);
        repeat (2) @(posedge CLK);
        #1;

        // Back-to-back stream with a three-cycle downstream stall.
        fork
            begin
                send(1'b0, 7'd15, 22'h240000, {16'h4080, 5'b00000});
                send(1'b0, 7'd15, 22'h1FFE00, {16'h4000, 5'b00001});
                send(1'b0, 7'd15, 22'h100200, {16'h3C00, 5'b00001});
                send(1'b0, 7'd15, 22'h100600, {16'h3C02, 5'b00001});
                send(1'b0, 7'd15, 22'h100000, {16'h3C00, 5'b00000});
            end
            begin
                repeat (2) @(posedge CLK);
                #1;
                OUT_READY = 1'b0;
                repeat (3) @(posedge CLK);
                #1;
                OUT_READY = 1'b1;
            end
        join
        repeat (3) @(posedge CLK);
        #1;

        // Overflow and underflow corners.
        send(1'b0, 7'd30, 22'h200000, {16'h7C00, 5'b00011});
`ifdef SUBNORMAL_EN
        send(1'b1, -7'sd3, 22'h100000, {16'h8040, 5'b00000});
`else
        send(1'b1, -7'sd3, 22'h100000, {16'h8000, 5'b00101});
`endif
        repeat (4) @(posedge CLK);
        #1;

        // Asynchronous reset with two operands held in the pipe.
        OUT_READY = 1'b0;
        send(1'b0, 7'd15, 22'h100000, {16'h3C00, 5'b00000});
        send(1'b0, 7'd16, 22'h100000, {16'h4000, 5'b00000});
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("midrst_q", {16'd0, Q}, 32'd0);
        check("midrst_flags", {27'd0, FLAGS}, 32'd0);
        repeat (2) @(negedge CLK);
        #2;
        RST_N     = 1'b1;
        OUT_READY = 1'b1;
        repeat (4) @(negedge CLK);
        check("no_stale_output", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK);
        #1;

        // Randomized traffic with random backpressure.
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge CLK);
                        #1;
                    end
                    r_s = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 15) == 0) r_m = 0;
                    else r_m = int'($urandom_range(1 << 20, (1 << 22) - 1));
                    if ($urandom_range(0, 3) == 0) r_m = (r_m & 32'h3FFC00) | 32'h200;
                    if ($urandom_range(0, 1) == 1) r_e = int'($urandom_range(0, 60)) - 15;
                    else r_e = int'($urandom_range(0, 127)) - 64;
                    send(r_s, 7'(r_e), 22'(r_m), model(r_s, r_e, r_m));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge CLK);
                    #1;
                    OUT_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join

        OUT_READY = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge CLK);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
